// File: rtl/aes_ctr_stream_if.sv
// aes_ctr_stream_if: word-stream handshakes plus the keystream request/response link to the AES core
interface aes_ctr_stream_if #(
  parameter int WSIZE = 32,
  parameter int BSIZE = 128
);
  logic [WSIZE-1:0] in_word;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [WSIZE-1:0] out_word;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic [BSIZE-1:0] ks_ctr;
  logic ks_req;
  logic ks_ack;
  logic [BSIZE-1:0] ks_data;
  logic ks_valid;
  modport master (
    input in_word, in_valid, in_last, out_ready, ks_ack, ks_data, ks_valid,
    output in_ready, out_word, out_valid, out_last, ks_ctr, ks_req
  );
  modport slave (
    output in_word, in_valid, in_last, out_ready, ks_ack, ks_data, ks_valid,
    input in_ready, out_word, out_valid, out_last, ks_ctr, ks_req
  );
endinterface

// File: rtl/aes_ctr_stream_engine.sv
// aes_ctr_stream_engine: AES counter-mode word stream engine, one block in flight, keystream from an external core
module aes_ctr_stream_engine #(
  parameter int WSIZE = 32,
  parameter int BSIZE = 128,
  parameter int CTRW = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic [BSIZE-1:0] nonce_in,
  input  logic set_nonce,
  input  logic enable,
  aes_ctr_stream_if.master bus,
  output logic [31:0] block_count,
  output logic busy
);
  localparam int WPB = BSIZE / WSIZE;
  localparam int IW = $clog2(WPB + 1);
  localparam logic [BSIZE-1:0] CMASK = {BSIZE{1'b1}} >> (BSIZE - CTRW);
  typedef enum logic [2:0] {IDLE, FILL, REQ, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [BSIZE-1:0] ctr, dbuf;
  logic [IW-1:0] idx, nwords;
  logic last_blk, in_fire, in_end, out_fire, out_end;
  assign in_fire = state == FILL && bus.in_valid;
  assign in_end = in_fire && (idx == IW'(WPB - 1) || bus.in_last);
  assign out_fire = state == DRAIN && bus.out_ready;
  assign out_end = idx == nwords - IW'(1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = enable && !set_nonce ? FILL : IDLE;
      FILL: state_nx = in_end ? REQ : FILL;
      REQ: state_nx = bus.ks_ack ? WAIT : REQ;
      WAIT: state_nx = bus.ks_valid ? DRAIN : WAIT;
      DRAIN: state_nx = out_fire && out_end ? (last_blk || !enable ? IDLE : FILL) : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = state == FILL;
    bus.ks_req = state == REQ;
    bus.ks_ctr = ctr;
    bus.out_valid = state == DRAIN;
    bus.out_word = state == DRAIN ? dbuf[BSIZE-1 -: WSIZE] : '0;
    bus.out_last = state == DRAIN && last_blk && out_end;
    busy = state != IDLE;
  end
  // First word of a block clears the buffer so unfilled words of a partial block read as zero.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ctr <= '0;
      dbuf <= '0;
      idx <= '0;
      nwords <= '0;
      last_blk <= 1'b0;
      block_count <= '0;
    end else begin
      if (state == IDLE && set_nonce) ctr <= nonce_in;
      if (state == REQ && bus.ks_ack) ctr <= (ctr & ~CMASK) | ((ctr + BSIZE'(1)) & CMASK);
      if (in_fire) begin
        dbuf <= (idx == '0 ? '0 : dbuf) | (BSIZE'(bus.in_word) << (BSIZE - WSIZE - int'(idx) * WSIZE));
        idx <= idx + IW'(1);
      end
      if (in_end) begin
        nwords <= idx + IW'(1);
        last_blk <= bus.in_last;
      end
      if (state == WAIT && bus.ks_valid) begin
        dbuf <= dbuf ^ bus.ks_data;
        idx <= '0;
      end
      if (out_fire) begin
        dbuf <= dbuf << WSIZE;
        idx <= out_end ? '0 : idx + IW'(1);
      end
      if (out_fire && out_end) block_count <= block_count + 32'd1;
    end
endmodule

// File: tb/tb_aes_ctr_stream_engine.sv
// tb_aes_ctr_stream_engine: randomized scenarios checked against a block-level CTR model
module tb_aes_ctr_stream_engine;
  logic clock = 1'b0;
  logic reset, set_nonce, enable, busy;
  logic [127:0] nonce_in, model_ctr;
  logic [31:0] block_count, model_count;
  int tests = 0;
  int fails = 0;
  aes_ctr_stream_if bus ();
  aes_ctr_stream_engine dut (
    .clock(clock), .reset(reset), .nonce_in(nonce_in), .set_nonce(set_nonce), .enable(enable),
    .bus(bus), .block_count(block_count), .busy(busy)
  );
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    set_nonce = 1'b0;
    enable = 1'b0;
    nonce_in = '0;
    bus.in_word = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    bus.ks_ack = 1'b0;
    bus.ks_data = '0;
    bus.ks_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_ctr = '0;
    model_count = '0;
    @(negedge clock);
  endtask

  task automatic load_nonce(input logic [127:0] v);
    nonce_in = v;
    set_nonce = 1'b1;
    @(negedge clock);
    set_nonce = 1'b0;
    model_ctr = v;
  endtask

  task automatic run_block(input int n, input bit last, input logic [127:0] ks, input int ack_dly,
                           input int vld_dly, input bit stall, input bit keep, input bit zero);
    logic [127:0] exp_blk;
    logic [31:0] w;
    int cyc;
    exp_blk = '0;
    for (int i = 0; i < n; i++) begin
      w = zero ? 32'h0 : $urandom;
      exp_blk[127-32*i -: 32] = w;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL in_ready_timeout word %0d: got %b want 1", i, bus.in_ready);
      end
      bus.in_word = w;
      bus.in_valid = 1'b1;
      bus.in_last = last && i == n - 1;
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      if (i < n - 1 && $urandom_range(3) == 0) @(negedge clock);
    end
    exp_blk = exp_blk ^ ks;
    tests++;
    if (bus.ks_req !== 1'b1) begin
      fails++;
      $display("FAIL req_latency: ks_req got %b want 1", bus.ks_req);
    end
    cyc = 0;
    while (bus.ks_req !== 1'b1 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    tests++;
    if (bus.ks_ctr !== model_ctr) begin
      fails++;
      $display("FAIL ks_ctr: got %h want %h", bus.ks_ctr, model_ctr);
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clock);
      tests++;
      if (bus.ks_req !== 1'b1 || bus.ks_ctr !== model_ctr) begin
        fails++;
        $display("FAIL req_hold: got req=%b ctr=%h want req=1 ctr=%h", bus.ks_req, bus.ks_ctr, model_ctr);
      end
    end
    bus.ks_ack = 1'b1;
    @(negedge clock);
    bus.ks_ack = 1'b0;
    model_ctr[31:0] = model_ctr[31:0] + 32'd1;
    repeat (vld_dly) @(negedge clock);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_out: out_valid got %b want 0", bus.out_valid);
    end
    enable = keep;
    bus.ks_data = ks;
    bus.ks_valid = 1'b1;
    @(negedge clock);
    bus.ks_valid = 1'b0;
    bus.ks_data = '0;
    for (int i = 0; i < n; i++) begin
      if (stall && i == 1) begin
        for (int s = 0; s < 5; s++) begin
          tests++;
          if (bus.out_valid !== 1'b1 || bus.out_word !== exp_blk[127-32*i -: 32]) begin
            fails++;
            $display("FAIL stall_hold: got v=%b w=%h want v=1 w=%h", bus.out_valid, bus.out_word, exp_blk[127-32*i -: 32]);
          end
          @(negedge clock);
        end
      end else if ($urandom_range(3) == 0) begin
        @(negedge clock);
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_word !== exp_blk[127-32*i -: 32] || bus.out_last !== (last && i == n - 1)) begin
        fails++;
        $display("FAIL out_word %0d: got v=%b w=%h l=%b want v=1 w=%h l=%b", i, bus.out_valid, bus.out_word,
                 bus.out_last, exp_blk[127-32*i -: 32], last && i == n - 1);
      end
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
    end
    model_count = model_count + 32'd1;
    tests++;
    if (block_count !== model_count) begin
      fails++;
      $display("FAIL block_count: got %0d want %0d", block_count, model_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.ks_req, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000", {bus.in_ready, bus.out_valid, bus.out_last, bus.ks_req, busy});
    end
    tests++;
    if (bus.out_word !== '0 || bus.ks_ctr !== '0 || block_count !== '0) begin
      fails++;
      $display("FAIL reset_data: got w=%h ctr=%h cnt=%0d want zeros", bus.out_word, bus.ks_ctr, block_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_nonce(128'hFF);
    enable = 1'b1;
    run_block(4, 1'b0, 128'h0123456789ABCDEF0011223344556677, 0, 2, 1'b0, 1'b1, 1'b1);
    run_block(4, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.ks_ctr !== 128'h101 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: got ctr=%h busy=%b want ctr=101 busy=0", bus.ks_ctr, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    load_nonce(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_FFFFFFFF);
    enable = 1'b1;
    run_block(4, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1'b0, 1'b1, 1'b0);
    run_block(4, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.ks_ctr !== 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_00000001) begin
      fails++;
      $display("FAIL wrap_ctr: got %h want AAAAAAAABBBBBBBBCCCCCCCC00000001", bus.ks_ctr);
    end
  endtask

  task automatic test_partial();
    do_reset();
    load_nonce({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    run_block(4, 1'b0, '1, 0, 1, 1'b0, 1'b1, 1'b0);
    run_block(2, 1'b1, '1, 0, 1, 1'b0, 1'b1, 1'b0);
    tests++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || block_count !== 32'd2) begin
      fails++;
      $display("FAIL partial_end: got busy=%b in_ready=%b cnt=%0d want 0 0 2", busy, bus.in_ready, block_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    load_nonce({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    run_block(4, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 3, 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_wait();
    do_reset();
    load_nonce({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.in_word = $urandom;
      bus.in_valid = 1'b1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    enable = 1'b0;
    tests++;
    if (bus.ks_req !== 1'b1) begin
      fails++;
      $display("FAIL rw_req: ks_req got %b want 1", bus.ks_req);
    end
    bus.ks_ack = 1'b1;
    @(negedge clock);
    bus.ks_ack = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.ks_req !== 1'b0 || bus.ks_ctr !== '0) begin
      fails++;
      $display("FAIL rw_reset: got busy=%b req=%b ctr=%h want 0 0 0", busy, bus.ks_req, bus.ks_ctr);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.ks_data = {$urandom, $urandom, $urandom, $urandom};
    bus.ks_valid = 1'b1;
    @(negedge clock);
    bus.ks_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_word !== '0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rw_late_ks: got v=%b w=%h busy=%b want 0 0 0", bus.out_valid, bus.out_word, busy);
      end
      @(negedge clock);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_set_nonce_fill();
    do_reset();
    load_nonce({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    @(negedge clock);
    nonce_in = ~model_ctr;
    set_nonce = 1'b1;
    @(negedge clock);
    set_nonce = 1'b0;
    run_block(4, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    bit last;
    do_reset();
    load_nonce({$urandom, $urandom, $urandom, 32'hFFFFFFFD});
    enable = 1'b1;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 4);
      last = n < 4 ? 1'b1 : 1'($urandom_range(1));
      run_block(n, last, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(1) == 0, b < 11, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_partial();
    test_stall();
    test_reset_wait();
    test_set_nonce_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
